// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: next-PC select codes and the bubble encoding.
package fetch_stage_pkg;

   localparam logic [1:0]  PCSEL_PLUS4 = 2'd0;
   localparam logic [1:0]  PCSEL_ALU   = 2'd1;
   localparam logic [31:0] NOP_ENC     = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/control inputs, icache port, I/X stage outputs and debug state.
interface fetch_stage_if;

   logic [1:0]  pc_sel;
   logic [31:0] alu_out;
   logic        inst_kill;
   logic        stall;
   logic [31:0] icache_dout;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] inst_I;
   logic [31:0] pc_I;
   logic [31:0] pc_X;
   logic [31:0] cycle_cnt;
   logic [31:0] fetch_cnt;
   logic [1:0]  state;

   modport master (
      input  pc_sel, alu_out, inst_kill, stall, icache_dout,
      output icache_addr, icache_re, inst_I, pc_I, pc_X, cycle_cnt, fetch_cnt, state
   );

   modport slave (
      output pc_sel, alu_out, inst_kill, stall, icache_dout,
      input  icache_addr, icache_re, inst_I, pc_I, pc_X, cycle_cnt, fetch_cnt, state
   );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: next-PC selection, I/X PC registers, redirect-while-stalled
// FSM (BOOT/RUN/PEND) and cycle/fetch counters.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_2000,
   parameter logic [31:0] NOP_INST = NOP_ENC
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_PEND = 2'd2
   } fetch_state_t;

   fetch_state_t state_q;
   logic [31:0]  pc_q;
   logic [31:0]  pc_x_q;
   logic [31:0]  redir_q;
   logic [31:0]  cycle_q;
   logic [31:0]  fetch_q;
   logic [31:0]  target;
   logic [31:0]  pc_next;
   logic         take_alu;
   logic         unused_alu_lsb;

   assign target         = {bus.alu_out[31:2], 2'b00};
   assign unused_alu_lsb = ^bus.alu_out[1:0];
   assign take_alu       = (bus.pc_sel == PCSEL_ALU);

   // pc_I always holds the address the icache is returning data for this cycle.
   always_comb begin
      pc_next = pc_q;
      if (reset) begin
         pc_next = RESET_PC;
      end else begin
         case (state_q)
            S_RUN:   pc_next = bus.stall ? pc_q : (take_alu ? target : pc_q + 32'd4);
            S_PEND:  pc_next = bus.stall ? pc_q : redir_q;
            default: pc_next = pc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         pc_x_q  <= 32'd0;
         redir_q <= 32'd0;
         cycle_q <= 32'd0;
         fetch_q <= 32'd0;
      end else begin
         pc_q    <= pc_next;
         cycle_q <= cycle_q + 32'd1;
         if (!bus.stall) pc_x_q <= pc_q;
         if (!bus.stall && state_q == S_RUN && !bus.inst_kill) fetch_q <= fetch_q + 32'd1;
         case (state_q)
            S_BOOT: state_q <= S_RUN;
            S_RUN: begin
               // A redirect seen while stalled is parked until the stall drops.
               if (bus.stall && take_alu) begin
                  redir_q <= target;
                  state_q <= S_PEND;
               end
            end
            S_PEND:  if (!bus.stall) state_q <= S_RUN;
            default: state_q <= S_BOOT;
         endcase
      end
   end

   assign bus.icache_addr = pc_next;
   assign bus.icache_re   = ~reset;
   assign bus.inst_I      = (state_q != S_RUN || bus.inst_kill) ? NOP_INST : bus.icache_dout;
   assign bus.pc_I        = pc_q;
   assign bus.pc_X        = pc_x_q;
   assign bus.cycle_cnt   = cycle_q;
   assign bus.fetch_cnt   = fetch_q;
   assign bus.state       = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, straight-line fetch, kill redirect, stall,
// redirect parked during stall, reset in PEND and PC wrap.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (32'h0000_2000),
      .NOP_INST (NOP_ENC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // icache model: one-cycle read latency, data tagged with the low address bits
   always @(posedge clk) bus.icache_dout <= {16'hA5A5, bus.icache_addr[15:0]};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic [1:0] sel, input logic kill,
                        input logic [31:0] alu);
      bus.stall     = st;
      bus.pc_sel    = sel;
      bus.inst_kill = kill;
      bus.alu_out   = alu;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(1'b0, PCSEL_PLUS4, 1'b0, 32'd0);
      tick();
      tick();

      check("rst_addr", bus.icache_addr, 32'h2000);
      check("rst_re", {31'd0, bus.icache_re}, 32'd0);
      check("rst_pc_I", bus.pc_I, 32'h2000);
      check("rst_pc_X", bus.pc_X, 32'd0);
      check("rst_cycle", bus.cycle_cnt, 32'd0);
      check("rst_fetch", bus.fetch_cnt, 32'd0);
      check("rst_state", {30'd0, bus.state}, {30'd0, ST_BOOT});

      reset = 1'b0;
      #1;
      check("boot_inst", bus.inst_I, NOP_ENC);
      check("boot_addr", bus.icache_addr, 32'h2000);
      check("boot_re", {31'd0, bus.icache_re}, 32'd1);
      tick();
      check("run_state", {30'd0, bus.state}, {30'd0, ST_RUN});
      check("run_cycle", bus.cycle_cnt, 32'd1);

      // straight-line fetch; pc_sel=3 must behave as PLUS4
      exp_q.push_back(32'h2000);
      exp_q.push_back(32'h2004);
      exp_q.push_back(32'h2008);
      exp_q.push_back(32'h200C);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, (i == 2) ? 2'd3 : PCSEL_PLUS4, 1'b0, 32'h0000_5555);
         exp_pc = exp_q.pop_front();
         #1;
         check("line_pc_I", bus.pc_I, exp_pc);
         check("line_inst", bus.inst_I, {16'hA5A5, exp_pc[15:0]});
         tick();
      end
      check("line_fetch", bus.fetch_cnt, 32'd4);
      check("line_cycle", bus.cycle_cnt, 32'd5);
      check("line_pc_X", bus.pc_X, 32'h200C);
      check("line_pc_I_end", bus.pc_I, 32'h2010);

      // plain stall for 3 cycles
      drive(1'b1, PCSEL_PLUS4, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_addr", bus.icache_addr, 32'h2010);
         tick();
      end
      check("stall_pc_I", bus.pc_I, 32'h2010);
      check("stall_pc_X", bus.pc_X, 32'h200C);
      check("stall_inst", bus.inst_I, 32'hA5A5_2010);
      check("stall_fetch", bus.fetch_cnt, 32'd4);
      check("stall_cycle", bus.cycle_cnt, 32'd8);

      // redirect with kill, unaligned target
      drive(1'b0, PCSEL_ALU, 1'b1, 32'h2103);
      #1;
      check("kill_inst", bus.inst_I, NOP_ENC);
      check("kill_addr", bus.icache_addr, 32'h2100);
      tick();
      drive(1'b0, PCSEL_PLUS4, 1'b0, 32'd0);
      #1;
      check("redir_pc_I", bus.pc_I, 32'h2100);
      check("redir_inst", bus.inst_I, 32'hA5A5_2100);
      check("redir_pc_X", bus.pc_X, 32'h2010);
      check("kill_fetch", bus.fetch_cnt, 32'd4);
      tick();

      // redirect while stalled, parked in PEND for two more stall cycles
      drive(1'b1, PCSEL_ALU, 1'b0, 32'h2200);
      #1;
      check("sredir_addr", bus.icache_addr, 32'h2104);
      tick();
      drive(1'b1, PCSEL_ALU, 1'b1, 32'h3000);
      #1;
      check("pend_state", {30'd0, bus.state}, {30'd0, ST_PEND});
      check("pend_inst", bus.inst_I, NOP_ENC);
      check("pend_addr", bus.icache_addr, 32'h2104);
      tick();
      drive(1'b1, PCSEL_PLUS4, 1'b0, 32'd0);
      #1;
      check("pend2_state", {30'd0, bus.state}, {30'd0, ST_PEND});
      tick();
      drive(1'b0, PCSEL_PLUS4, 1'b0, 32'd0);
      #1;
      check("release_addr", bus.icache_addr, 32'h2200);
      check("release_inst", bus.inst_I, NOP_ENC);
      tick();
      check("after_state", {30'd0, bus.state}, {30'd0, ST_RUN});
      check("after_pc_I", bus.pc_I, 32'h2200);
      check("after_inst", bus.inst_I, 32'hA5A5_2200);
      check("after_addr", bus.icache_addr, 32'h2204);
      check("after_fetch", bus.fetch_cnt, 32'd5);
      check("after_cycle", bus.cycle_cnt, 32'd14);
      tick();

      // reset while a redirect is parked
      drive(1'b1, PCSEL_ALU, 1'b0, 32'h2300);
      tick();
      check("pend3_state", {30'd0, bus.state}, {30'd0, ST_PEND});
      reset = 1'b1;
      #1;
      check("rst2_addr", bus.icache_addr, 32'h2000);
      check("rst2_re", {31'd0, bus.icache_re}, 32'd0);
      tick();
      reset = 1'b0;
      drive(1'b0, PCSEL_PLUS4, 1'b0, 32'd0);
      #1;
      check("rst2_state", {30'd0, bus.state}, {30'd0, ST_BOOT});
      check("rst2_pc_I", bus.pc_I, 32'h2000);
      check("rst2_pc_X", bus.pc_X, 32'd0);
      check("rst2_fetch", bus.fetch_cnt, 32'd0);
      check("rst2_cycle", bus.cycle_cnt, 32'd0);
      check("rst2_addr_boot", bus.icache_addr, 32'h2000);
      tick();
      check("restart_pc_I", bus.pc_I, 32'h2000);
      check("restart_inst", bus.inst_I, 32'hA5A5_2000);
      tick();
      check("restart_pc_next", bus.pc_I, 32'h2004);

      // 32-bit PC wrap
      drive(1'b0, PCSEL_ALU, 1'b1, 32'hFFFF_FFFF);
      #1;
      check("wrap_target", bus.icache_addr, 32'hFFFF_FFFC);
      tick();
      drive(1'b0, PCSEL_PLUS4, 1'b0, 32'd0);
      #1;
      check("wrap_pc_I", bus.pc_I, 32'hFFFF_FFFC);
      check("wrap_addr", bus.icache_addr, 32'd0);
      tick();
      check("wrap_pc_zero", bus.pc_I, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
